// File: rtl/usb_buffer_pkg.sv
// Shared types and defaults for the USB frame buffer.
//   usb_entry_t  : one FIFO entry, {last, data[7:0]}
//   ufb_state_t  : write-side frame FSM states
//   UFB_*        : default parameter values and entry width
package usb_buffer_pkg;

    localparam int UFB_DEPTH_DEFAULT = 512;
    localparam int UFB_CNT_W_DEFAULT = 16;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } usb_entry_t;

    localparam int UFB_ENTRY_W = $bits(usb_entry_t);

    typedef enum logic [1:0] {
        IDLE,
        IN_FRAME,
        DROP
    } ufb_state_t;

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port frame storage: one write port, one read port with a
// registered, enable-gated output (the output holds its value while re_i=0).
//   clk_i   : clock
//   we_i    : write enable, waddr_i/wdata_i : write address/entry
//   re_i    : read enable,  raddr_i         : read address
//   rdata_o : entry read on the previous enabled cycle
module frame_ram
    import usb_buffer_pkg::*;
#(
    parameter  int DEPTH = UFB_DEPTH_DEFAULT,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                   clk_i,
    input  logic                   we_i,
    input  logic [AW-1:0]          waddr_i,
    input  logic [UFB_ENTRY_W-1:0] wdata_i,
    input  logic                   re_i,
    input  logic [AW-1:0]          raddr_i,
    output logic [UFB_ENTRY_W-1:0] rdata_o
);

    logic [UFB_ENTRY_W-1:0] mem_q [DEPTH];
    logic [UFB_ENTRY_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/usb_frame_buffer.sv
// Frame-granular FIFO between the BLE packet analyzer and a USB endpoint.
// Bytes of a frame are accumulated in the FIFO and only become visible to
// the reader once the whole frame has arrived; a frame that does not fit is
// rolled back in full and counted as dropped.
//   clk_i/rst_i        : clock, synchronous active-high reset
//   data_i/valid_i/frame_i : analyzer byte stream, frame_i brackets a frame
//   usb_data_o/usb_valid_o/usb_last_o/usb_ready_i : FWFT valid/ready output
//   overflow_o         : one-cycle pulse per dropped frame
//   dropped_cnt_o      : saturating dropped-frame count
//   level_o            : committed entries still in RAM
module usb_frame_buffer
    import usb_buffer_pkg::*;
#(
    parameter  int DEPTH = UFB_DEPTH_DEFAULT,
    parameter  int CNT_W = UFB_CNT_W_DEFAULT,
    localparam int AW    = $clog2(DEPTH),
    localparam int PW    = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [7:0]       data_i,
    input  logic             valid_i,
    input  logic             frame_i,
    output logic [7:0]       usb_data_o,
    output logic             usb_valid_o,
    output logic             usb_last_o,
    input  logic             usb_ready_i,
    output logic             overflow_o,
    output logic [CNT_W-1:0] dropped_cnt_o,
    output logic [PW-1:0]    level_o
);

    localparam logic [PW-1:0]    DEPTH_P = PW'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Write side
    ufb_state_t       state_q, state_d;
    logic             frame_q;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    cmt_ptr_q, cmt_ptr_d;
    logic             pend_valid_q, pend_valid_d;
    logic [7:0]       pend_data_q, pend_data_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] dropped_q, dropped_d;

    // Read side
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;      // entries handed to the output register
    logic [PW-1:0]    fetch_ptr_q, fetch_ptr_d; // next RAM address to read
    logic             s1_valid_q, s1_valid_d;  // RAM output register holds an unconsumed entry
    logic             out_valid_q, out_valid_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_last_q, out_last_d;

    logic             frame_rise, frame_fall, byte_in, space_ok;
    logic [PW-1:0]    used_w;
    logic             ram_we, ram_re, hs, s1_move;
    usb_entry_t       ram_wentry, ram_rentry;
    logic [UFB_ENTRY_W-1:0] ram_rdata;

    assign frame_rise = frame_i & ~frame_q;
    assign frame_fall = ~frame_i & frame_q;
    assign byte_in    = valid_i & frame_i;

    // Occupancy is measured against the reader's current pointer only; a
    // read completing in this cycle does not make room for this write.
    assign used_w   = wr_ptr_q - rd_ptr_q;
    assign space_ok = (used_w < DEPTH_P);

    // ---------------------------------------------------------------- write FSM
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        cmt_ptr_d    = cmt_ptr_q;
        pend_valid_d = pend_valid_q;
        pend_data_d  = pend_data_q;
        overflow_d   = 1'b0;
        dropped_d    = dropped_q;
        ram_we       = 1'b0;
        ram_wentry   = '{last: 1'b0, data: pend_data_q};

        case (state_q)
            IDLE: begin
                if (frame_rise) begin
                    state_d      = IN_FRAME;
                    pend_valid_d = valid_i;
                    pend_data_d  = data_i;
                end
            end

            IN_FRAME: begin
                if (frame_fall) begin
                    state_d      = IDLE;
                    pend_valid_d = 1'b0;
                    if (pend_valid_q) begin
                        if (space_ok) begin
                            ram_we          = 1'b1;
                            ram_wentry.last = 1'b1;
                            wr_ptr_d        = wr_ptr_q + 1'b1;
                            cmt_ptr_d       = wr_ptr_q + 1'b1;
                        end else begin
                            // Final byte does not fit: roll back the whole frame.
                            wr_ptr_d   = cmt_ptr_q;
                            overflow_d = 1'b1;
                            if (dropped_q != CNT_MAX) begin
                                dropped_d = dropped_q + 1'b1;
                            end
                        end
                    end
                end else if (byte_in) begin
                    if (pend_valid_q) begin
                        if (space_ok) begin
                            ram_we      = 1'b1;
                            wr_ptr_d    = wr_ptr_q + 1'b1;
                            pend_data_d = data_i;
                        end else begin
                            state_d      = DROP;
                            pend_valid_d = 1'b0;
                        end
                    end else begin
                        pend_valid_d = 1'b1;
                        pend_data_d  = data_i;
                    end
                end
            end

            DROP: begin
                pend_valid_d = 1'b0;
                if (frame_fall) begin
                    state_d    = IDLE;
                    wr_ptr_d   = cmt_ptr_q;
                    overflow_d = 1'b1;
                    if (dropped_q != CNT_MAX) begin
                        dropped_d = dropped_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------- read side
    // Two stages: RAM output register (s1) then the USB output register. An
    // entry counts as read (rd_ptr) only once it moves into the output register,
    // so level_o excludes exactly the byte currently presented.
    assign ram_rentry = usb_entry_t'(ram_rdata);
    assign hs         = out_valid_q & usb_ready_i;
    assign s1_move    = s1_valid_q & (~out_valid_q | hs);
    assign ram_re     = (cmt_ptr_q != fetch_ptr_q) & (~s1_valid_q | s1_move);

    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        fetch_ptr_d = fetch_ptr_q;
        s1_valid_d  = s1_valid_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;

        if (ram_re) begin
            fetch_ptr_d = fetch_ptr_q + 1'b1;
            s1_valid_d  = 1'b1;
        end else if (s1_move) begin
            s1_valid_d  = 1'b0;
        end

        if (s1_move) begin
            rd_ptr_d    = rd_ptr_q + 1'b1;
            out_valid_d = 1'b1;
            out_data_d  = ram_rentry.data;
            out_last_d  = ram_rentry.last;
        end else if (hs) begin
            out_valid_d = 1'b0;
        end
    end

    // ---------------------------------------------------------------- registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            frame_q      <= 1'b0;
            wr_ptr_q     <= '0;
            cmt_ptr_q    <= '0;
            pend_valid_q <= 1'b0;
            pend_data_q  <= '0;
            overflow_q   <= 1'b0;
            dropped_q    <= '0;
            rd_ptr_q     <= '0;
            fetch_ptr_q  <= '0;
            s1_valid_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_q      <= frame_i;
            wr_ptr_q     <= wr_ptr_d;
            cmt_ptr_q    <= cmt_ptr_d;
            pend_valid_q <= pend_valid_d;
            pend_data_q  <= pend_data_d;
            overflow_q   <= overflow_d;
            dropped_q    <= dropped_d;
            rd_ptr_q     <= rd_ptr_d;
            fetch_ptr_q  <= fetch_ptr_d;
            s1_valid_q   <= s1_valid_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
        end
    end

    frame_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (ram_wentry),
        .re_i    (ram_re),
        .raddr_i (fetch_ptr_q[AW-1:0]),
        .rdata_o (ram_rdata)
    );

    assign usb_data_o    = out_data_q;
    assign usb_valid_o   = out_valid_q;
    assign usb_last_o    = out_last_q;
    assign overflow_o    = overflow_q;
    assign dropped_cnt_o = dropped_q;
    assign level_o       = cmt_ptr_q - rd_ptr_q;

endmodule
